// File: rtl/box_anim_pkg.sv
// rtl/box_anim_pkg.sv - shared types and constants for the box animator
package box_anim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        ERASE,
        MOVE
    } state_t;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [15:0] COLOUR_BLACK = '0;

endpackage

// File: rtl/box_animator_if.sv
// rtl/box_animator_if.sv - pixel write port toward the VGA adapter
interface box_animator_if
    import box_anim_pkg::*;
#(
    parameter int COLOUR_W = 3
);
    logic [X_W-1:0]      oX;
    logic [Y_W-1:0]      oY;
    logic [COLOUR_W-1:0] oColour;
    logic                oPlot;
    logic                oDone;

    modport master (output oX, output oY, output oColour, output oPlot, output oDone);
    modport slave  (input  oX, input  oY, input  oColour, input  oPlot, input  oDone);
endinterface

// File: rtl/box_scan_counter.sv
// rtl/box_scan_counter.sv - raster cx/cy counter over the box, shared by DRAW and ERASE
module box_scan_counter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic       last
);
    logic [3:0] cx_q, cx_d;
    logic [3:0] cy_q, cy_d;
    logic       cx_end, cy_end;

    assign cx_end = (cx_q == 4'(BOX_W - 1));
    assign cy_end = (cy_q == 4'(BOX_H - 1));
    assign last   = en && cx_end && cy_end;
    assign cx     = cx_q;
    assign cy     = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (en) begin
            if (cx_end) begin
                cx_d = 4'd0;
                cy_d = cy_end ? 4'd0 : cy_q + 4'd1;
            end else begin
                cx_d = cx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx_q <= 4'd0;
            cy_q <= 4'd0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end
endmodule

// File: rtl/box_animator.sv
// rtl/box_animator.sv - draw/wait/erase/move box animator; BOX_ANIM_BOUNCE_EN enables bouncing motion
module box_animator
    import box_anim_pkg::*;
#(
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 120,
    parameter int DELAY    = 12499999,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    box_animator_if.master      vga
);
    localparam int DLY_W = $clog2(DELAY + 1);
    localparam logic [X_W-1:0]   X_LIM    = X_W'(X_MAX - BOX_W);
    localparam logic [Y_W-1:0]   Y_LIM    = Y_W'(Y_MAX - BOX_H);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY - 1);

    state_t              state_q, state_d;
    logic [X_W-1:0]      pos_x_q, pos_x_d;
    logic [Y_W-1:0]      pos_y_q, pos_y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [X_W-1:0]      ox_q, ox_d;
    logic [Y_W-1:0]      oy_q, oy_d;
    logic [COLOUR_W-1:0] ocol_q, ocol_d;
    logic                oplot_q, oplot_d;
    logic                odone_q, odone_d;
`ifdef BOX_ANIM_BOUNCE_EN
    logic                dir_x_q, dir_x_d;  // 1 = moving +1
    logic                dir_y_q, dir_y_d;
`endif

    logic       scan_en, scan_last;
    logic [3:0] cx, cy;

    assign scan_en = (state_q == DRAW) || (state_q == ERASE);

    box_scan_counter #(.BOX_W(BOX_W), .BOX_H(BOX_H)) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .en     (scan_en),
        .cx     (cx),
        .cy     (cy),
        .last   (scan_last)
    );

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        colour_d = colour_q;
        dly_d    = dly_q;
        ox_d     = '0;
        oy_d     = '0;
        ocol_d   = '0;
        oplot_d  = 1'b0;
        odone_d  = 1'b0;
`ifdef BOX_ANIM_BOUNCE_EN
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    pos_x_d  = (iX > X_LIM) ? X_LIM : iX;
                    pos_y_d  = (iY > Y_LIM) ? Y_LIM : iY;
                    colour_d = iColour;
`ifdef BOX_ANIM_BOUNCE_EN
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
`endif
                    state_d  = DRAW;
                end
            end
            DRAW, ERASE: begin
                oplot_d = 1'b1;
                ox_d    = pos_x_q + X_W'(cx);
                oy_d    = pos_y_q + Y_W'(cy);
                ocol_d  = (state_q == DRAW) ? colour_q : COLOUR_BLACK[COLOUR_W-1:0];
                if (scan_last)
                    state_d = (state_q == DRAW) ? WAIT : MOVE;
            end
            WAIT: begin
                if (dly_q == DLY_LAST) begin
                    dly_d   = '0;
                    state_d = ERASE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            MOVE: begin
                odone_d = 1'b1;
`ifdef BOX_ANIM_BOUNCE_EN
                // Reflect at the edge so the whole box stays on screen.
                if (dir_x_q) begin
                    if (pos_x_q == X_LIM) begin
                        dir_x_d = 1'b0;
                        pos_x_d = pos_x_q - X_W'(1);
                    end else begin
                        pos_x_d = pos_x_q + X_W'(1);
                    end
                end else if (pos_x_q == '0) begin
                    dir_x_d = 1'b1;
                    pos_x_d = pos_x_q + X_W'(1);
                end else begin
                    pos_x_d = pos_x_q - X_W'(1);
                end
                if (dir_y_q) begin
                    if (pos_y_q == Y_LIM) begin
                        dir_y_d = 1'b0;
                        pos_y_d = pos_y_q - Y_W'(1);
                    end else begin
                        pos_y_d = pos_y_q + Y_W'(1);
                    end
                end else if (pos_y_q == '0) begin
                    dir_y_d = 1'b1;
                    pos_y_d = pos_y_q + Y_W'(1);
                end else begin
                    pos_y_d = pos_y_q - Y_W'(1);
                end
`endif
                state_d = enable ? DRAW : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            colour_q <= '0;
            dly_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            ocol_q   <= '0;
            oplot_q  <= 1'b0;
            odone_q  <= 1'b0;
`ifdef BOX_ANIM_BOUNCE_EN
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            colour_q <= colour_d;
            dly_q    <= dly_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            ocol_q   <= ocol_d;
            oplot_q  <= oplot_d;
            odone_q  <= odone_d;
`ifdef BOX_ANIM_BOUNCE_EN
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
`endif
        end
    end

    assign vga.oX      = ox_q;
    assign vga.oY      = oy_q;
    assign vga.oColour = ocol_q;
    assign vga.oPlot   = oplot_q;
    assign vga.oDone   = odone_q;
endmodule

// File: doc/box_animator.md
# box_animator

Parametrised rectangle animator for the 160x120 VGA plotting path. Each frame it draws a BOX_W x BOX_H box one pixel per cycle, holds it for a programmable delay, erases it to black, and updates its position. Generalises the fixed 4x4 draw/wait/erase loop with configurable size, delay, screen limits and optional bouncing motion. Sits between the user/game logic and the VGA adapter's x/y/colour/plot write port.

## Interface
- BOX_W, 4: box width in pixels (1..16)
- BOX_H, 4: box height in pixels (1..16)
- X_MAX, 160: screen width; legal x is 0..X_MAX-1
- Y_MAX, 120: screen height; legal y is 0..Y_MAX-1
- DELAY, 12499999: WAIT length in cycles (>=1)
- COLOUR_W, 3: colour width
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  start/continue animation
- iX  in  8  start x (top-left), sampled on leaving IDLE
- iY  in  7  start y (top-left), sampled on leaving IDLE
- iColour  in  COLOUR_W  draw colour, sampled on leaving IDLE
- oX  out  8  pixel x to VGA adapter
- oY  out  7  pixel y to VGA adapter
- oColour  out  COLOUR_W  pixel colour
- oPlot  out  1  write strobe, one pixel per high cycle
- oDone  out  1  one-cycle pulse at end of each frame (MOVE)

## Operation
- States: IDLE, DRAW, WAIT, ERASE, MOVE.
- IDLE: oPlot=0. When enable=1: load posX/posY from iX/iY (clamped to X_MAX-BOX_W, Y_MAX-BOX_H), latch colour, dirX=dirY=+1, go DRAW.
- DRAW: BOX_W*BOX_H cycles, raster order (column counter cx fastest, then row cy). Each cycle oPlot=1, oX=posX+cx, oY=posY+cy, oColour=latched colour. After last pixel (cx=BOX_W-1, cy=BOX_H-1) go WAIT; counters return to 0.
- WAIT: oPlot=0; delay counter counts 0..DELAY-1, then ERASE. Counter cleared on exit.
- ERASE: identical scan to DRAW with oColour=0 (black), same posX/posY.
- MOVE: one cycle, oDone=1, oPlot=0, position update (see Configuration). Then DRAW if enable=1, else IDLE.
- enable dropping mid-frame is ignored until MOVE: a drawn box is always erased.
- iX/iY/iColour changes outside IDLE have no effect.
- Arithmetic: posX+cx and posY+cy never overflow given clamping; delay counter width $clog2(DELAY+1).

## Timing
- All outputs registered; oX/oY/oColour/oPlot for pixel k appear together.
- Reset (async, any state): state=IDLE, oX=0, oY=0, oColour=0, oPlot=0, oDone=0, counters=0, pos=0, dir=+1.
- Latency enable->first oPlot: 2 cycles (IDLE sample, first DRAW output).
- Frame period: 2*BOX_W*BOX_H + DELAY + 1 cycles.
- Reset mid-DRAW/ERASE leaves partial pixels on screen; not this block's concern.

## Configuration
- BOX_ANIM_BOUNCE_EN defined: in MOVE, posX steps by dirX; if dirX=+1 and posX+BOX_W==X_MAX, flip dirX and step -1; if dirX=-1 and posX==0, flip and step +1. Y identical with Y_MAX. Box always stays fully on screen.
- Undefined: MOVE leaves position unchanged (static blinking box); dir registers absent.

## Structure
- Package box_anim_pkg: state enum typedef (IDLE, DRAW, WAIT, ERASE, MOVE), COLOUR_BLACK constant, X_W=8/Y_W=7 constants.
- One sub-module box_scan_counter (BOX_W, BOX_H): enable-driven cx/cy raster counter with last-pixel flag; shared by DRAW and ERASE.

## Test plan
Bench params BOX_W=4, BOX_H=4, DELAY=3, X_MAX=160, Y_MAX=120 unless noted.
- Reset then enable=1, iX=10, iY=20, iColour=3'b101 -> 16 oPlot cycles, first (10,20), last (13,23), colour 5; then 3 idle cycles; 16 erase cycles with colour 0 on same coords; oDone pulse at cycle 36.
- iX=158, iY=118 -> start clamped to (156,116); first pixel (156,116).
- BOUNCE_EN, start (155,0): frame2 at (156,1), frame3 at (155,2) (x reflected), y continues increasing.
- enable deasserted during DRAW -> WAIT/ERASE/MOVE complete, then IDLE, oPlot stays 0.
- resetn pulsed low mid-ERASE -> all outputs 0 immediately, IDLE; re-enable restarts from new iX/iY.
- Without BOUNCE_EN, 3 frames -> every frame draws at identical (10,20) origin.
